gpio_debounce: RTL and testbench
================================

# gpio_debounce

Per-bit input conditioning stage for the GPIO pins. It sits between the raw pad inputs and the input port of `tcb_gpio`. It synchronizes each bit to `clk`, debounces it with a programmable stability count, and detects rising and falling edges on the debounced value. Detected edges are latched into sticky per-bit event flags, and a single interrupt line is derived from them for the GPIO controller and the interrupt logic.

## Interface
Parameters:
- `GW`, 32, GPIO width (number of conditioned bits)
- `CW`, 8, debounce counter width
- `PW`, 16, prescaler counter width

Ports:
- `clk`  input  1  clock
- `rst`  input  1  reset, asynchronous, active-high
- `gpio_i`  input  GW  raw asynchronous pad inputs
- `cfg_len`  input  CW  debounce length; a new value must persist for `cfg_len+1` ticks
- `cfg_div`  input  PW  prescaler divisor; one tick every `cfg_div+1` cycles
- `cfg_rise`  input  GW  per-bit rising-edge event enable
- `cfg_fall`  input  GW  per-bit falling-edge event enable
- `cfg_ien`  input  GW  per-bit interrupt enable
- `evt_clr`  input  GW  write-1-to-clear pulse for event flags, valid for one cycle
- `gpio_o`  output  GW  debounced input value, feeds `tcb_gpio` input register
- `evt_o`  output  GW  sticky event flags
- `irq`  output  1  interrupt, equal to `|(evt_o & cfg_ien)`

## Operation
- Clocking and reset:
  - One clock domain, `clk`.
  - `rst` is asynchronous and active-high.
  - All flops are reset to 0. This covers the synchronizer stages, the debounce counters, `gpio_o`, `evt_o` and the prescaler.
  - Hence `irq` resets to 0.
- Synchronizer: two flops per bit, `gpio_i` → `s1` → `s2`. No other logic samples `gpio_i`.
- Tick generation:
  - A prescaler counter `div` increments every cycle.
  - When `div >= cfg_div`, `tick=1` and `div` returns to 0.
  - `cfg_div=0` gives a tick every cycle.
- Debounce, per bit i, evaluated every cycle:
  - If `s2[i] == gpio_o[i]`: `cnt[i] <= 0`.
  - Else if `tick` and `cnt[i] >= cfg_len`: `gpio_o[i] <= s2[i]` and `cnt[i] <= 0`.
  - Else if `tick`: `cnt[i] <= cnt[i]+1`.
  - Otherwise `cnt[i]` holds.
  - Any glitch that returns to the old value before commit zeroes the counter.
  - `cnt` never exceeds `cfg_len`, so no overflow handling is needed.
  - Using `>=` makes a lowered `cfg_len` take effect on the next tick.
- Edge detection:
  - `rise[i]` is the `gpio_o[i]` 0→1 commit and `fall[i]` is the 1→0 commit.
  - Both are combinational from the commit condition, active in the same cycle `gpio_o` is updated.
- Event flags:
  - Set term: `set = (rise & cfg_rise) | (fall & cfg_fall)`.
  - Update: `evt_o <= (evt_o & ~evt_clr) | set`.
  - Set wins over a simultaneous clear.
- Interrupt: `irq` is combinational from `evt_o` and `cfg_ien`. Masking a bit never clears its flag.
- Configuration changes take effect immediately. No shadowing.

## Timing
- Pad to `s2`: 2 cycles.
- A clean step on `gpio_i[i]` appears on `gpio_o[i]` after 2 cycles plus `cfg_len+1` ticks.
  - With `cfg_div=0`, that is `cfg_len+3` cycles after the first `clk` edge that samples the new level.
- `evt_o[i]` sets on the same edge that updates `gpio_o[i]`. `irq` follows combinationally in that same cycle.
- `evt_clr` takes effect on the next edge. The flag reads 0 from then on unless it is set again.
- Reset asserted mid-count:
  - Counters, outputs, flags and prescaler clear immediately (asynchronous).
  - After deassertion, a pad held at 1 re-qualifies from scratch and produces a rising event.

## Configuration
- Macro `GPIO_DEBOUNCE_PRESCALER_EN`.
- Defined:
  - The prescaler is built as described.
  - `cfg_div` is used.
- Undefined:
  - No prescaler flops; `tick` is tied to 1.
  - `cfg_div` is ignored; the port stays for interface stability.
  - Debounce length is `cfg_len+1` cycles.

## Test plan
- Reset release with `gpio_i=0`, `cfg_len=3`, `cfg_div=0`, `cfg_rise` all ones; step bit 0 high → `gpio_o[0]` rises exactly 6 cycles after the sampling edge, and `evt_o[0]=1` on the same edge.
- Same configuration, pulse bit 5 high for 3 cycles then low → `gpio_o[5]` stays 0 and `evt_o[5]` stays 0.
- Macro defined, `cfg_div=9`, `cfg_len=1`, step bit 2 high → `gpio_o[2]` rises 2 cycles plus 2 ticks (20 cycles) later, with ±9 cycles of prescaler phase.
- `cfg_fall[7]=1`, `cfg_ien[7]=0`, drop bit 7 → `evt_o[7]=1` and `irq=0`; then set `cfg_ien[7]=1` → `irq=1` in the same cycle.
- Pulse `evt_clr[7]` in the same cycle as a new fall commit on bit 7 → `evt_o[7]` remains 1; a lone `evt_clr[7]` pulse afterwards → 0 next cycle, and `irq=0`.
- Assert `rst` while `cnt[3]=2` with a pending change → all outputs 0 immediately; after release with the pad held at 1, a full `cfg_len+3` cycle requalification is required.

Source files
------------

// File: rtl/gpio_debounce_if.sv
// rtl/gpio_debounce_if.sv - pad, configuration and event signals of the GPIO input conditioner
interface gpio_debounce_if #(
  parameter int GW = 32,
  parameter int CW = 8,
  parameter int PW = 16
);
  logic [GW-1:0] gpio_i;
  logic [CW-1:0] cfg_len;
  logic [PW-1:0] cfg_div;
  logic [GW-1:0] cfg_rise;
  logic [GW-1:0] cfg_fall;
  logic [GW-1:0] cfg_ien;
  logic [GW-1:0] evt_clr;
  logic [GW-1:0] gpio_o;
  logic [GW-1:0] evt_o;
  logic          irq;

  modport master (
    output gpio_i, cfg_len, cfg_div, cfg_rise, cfg_fall, cfg_ien, evt_clr,
    input  gpio_o, evt_o, irq
  );

  modport slave (
    input  gpio_i, cfg_len, cfg_div, cfg_rise, cfg_fall, cfg_ien, evt_clr,
    output gpio_o, evt_o, irq
  );
endinterface

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - synchronize, debounce and edge-detect GPIO pads into sticky events and irq
// Optional prescaler built when GPIO_DEBOUNCE_PRESCALER_EN is defined; otherwise tick is every cycle.
module gpio_debounce #(
  parameter int GW = 32,
  parameter int CW = 8,
  parameter int PW = 16
) (
  input  logic              clk,
  input  logic              rst,
  gpio_debounce_if.slave    bus
);

  logic [GW-1:0] s1;
  logic [GW-1:0] s2;
  logic [GW-1:0] gpio_q;
  logic [GW-1:0] evt_q;
  logic [CW-1:0] cnt [GW];
  logic [GW-1:0] diff;
  logic [GW-1:0] commit;
  logic [GW-1:0] rise;
  logic [GW-1:0] fall;
  logic [GW-1:0] set;
  logic          tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.gpio_i;
      s2 <= s1;
    end
  end

`ifdef GPIO_DEBOUNCE_PRESCALER_EN
  logic [PW-1:0] div;

  // >= so that lowering cfg_div below the running count still wraps at once
  assign tick = (div >= bus.cfg_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end
`else
  logic [PW-1:0] unused_cfg_div;

  assign unused_cfg_div = bus.cfg_div;
  assign tick           = 1'b1;
`endif

  always_comb begin
    diff   = s2 ^ gpio_q;
    commit = '0;
    for (int i = 0; i < GW; i++) begin
      commit[i] = diff[i] & tick & (cnt[i] >= bus.cfg_len);
    end
  end

  assign rise = commit & s2;
  assign fall = commit & ~s2;
  assign set  = (rise & bus.cfg_rise) | (fall & bus.cfg_fall);

  // A sample matching the output restarts qualification, which also swallows glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < GW; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < GW; i++) begin
        if (!diff[i] || commit[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_q <= '0;
      evt_q  <= '0;
    end else begin
      gpio_q <= gpio_q ^ commit;
      evt_q  <= (evt_q & ~bus.evt_clr) | set;
    end
  end

  assign bus.gpio_o = gpio_q;
  assign bus.evt_o  = evt_q;
  assign bus.irq    = |(evt_q & bus.cfg_ien);

endmodule

// File: tb/tb_gpio_debounce.sv
// tb/tb_gpio_debounce.sv - directed table, corner sequences and randomized model check of gpio_debounce
module tb_gpio_debounce;
  localparam int GW = 32;
  localparam int CW = 8;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gpio_debounce_if #(.GW(GW), .CW(CW), .PW(PW)) bus ();
  gpio_debounce #(.GW(GW), .CW(CW), .PW(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int bitn;
    int len;
    int width;
    int exp_evt;
    int exp_edges;
  } vec_t;

  vec_t tbl [5];

  logic [GW-1:0] m_s1, m_s2, m_out, m_evt;
  logic [63:0]   hd [GW];
  logic [63:0]   ht;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.gpio_i   = '0;
    bus.cfg_len  = '0;
    bus.cfg_div  = '0;
    bus.cfg_rise = '0;
    bus.cfg_fall = '0;
    bus.cfg_ien  = '0;
    bus.evt_clr  = '0;
    step();
    step();
    check("rst_gpio", bus.gpio_o, 0);
    check("rst_evt", bus.evt_o, 0);
    check("rst_irq", bus.irq, 0);
  endtask

  // Reference: a change commits on a tick once the trailing run of differing
  // samples has contained cfg_len+1 ticks; the commit closes that run.
  task automatic model_edge(input int c, input int d);
    logic          tk;
    logic [GW-1:0] cm;
    int            n;
    tk = ((c % (d + 1)) == d);
    ht = {ht[62:0], tk};
    cm = '0;
    for (int i = 0; i < GW; i++) begin
      hd[i] = {hd[i][62:0], m_s2[i] ^ m_out[i]};
      n = 0;
      for (int j = 0; j < 64; j++) begin
        if (!hd[i][j]) break;
        n += ht[j];
      end
      if (tk && hd[i][0] && n >= int'(bus.cfg_len) + 1) begin
        cm[i]    = 1'b1;
        hd[i][0] = 1'b0;
      end
    end
    m_evt = (m_evt & ~bus.evt_clr) |
            (cm & m_s2 & bus.cfg_rise) | (cm & ~m_s2 & bus.cfg_fall);
    m_out = m_out ^ cm;
    m_s2  = m_s1;
    m_s1  = bus.gpio_i;
  endtask

  initial begin
    int first, evt_at, n, d;

    tbl[0] = '{bitn: 0,  len: 3, width: 0, exp_evt: 1, exp_edges: 6};
    tbl[1] = '{bitn: 5,  len: 3, width: 3, exp_evt: 0, exp_edges: 0};
    tbl[2] = '{bitn: 9,  len: 0, width: 0, exp_evt: 1, exp_edges: 3};
    tbl[3] = '{bitn: 12, len: 5, width: 0, exp_evt: 1, exp_edges: 8};
    tbl[4] = '{bitn: 20, len: 2, width: 3, exp_evt: 1, exp_edges: 5};

    for (int r = 0; r < 5; r++) begin
      do_reset();
      bus.cfg_len  = CW'(tbl[r].len);
      bus.cfg_rise = '1;
      rst = 1'b0;
      step();
      bus.gpio_i[tbl[r].bitn] = 1'b1;
      first  = 0;
      evt_at = 0;
      for (int k = 1; k <= 20; k++) begin
        step();
        if (tbl[r].width != 0 && k == tbl[r].width) bus.gpio_i[tbl[r].bitn] = 1'b0;
        if (first == 0 && bus.gpio_o[tbl[r].bitn]) begin
          first  = k;
          evt_at = int'(bus.evt_o[tbl[r].bitn]);
        end
      end
      check($sformatf("tbl%0d_latency", r), first, tbl[r].exp_edges);
      check($sformatf("tbl%0d_evt_on_commit", r), evt_at, tbl[r].exp_evt);
      check($sformatf("tbl%0d_evt_final", r), bus.evt_o[tbl[r].bitn], tbl[r].exp_evt);
    end

    // Falling event masked, then unmasked without a clock edge
    do_reset();
    bus.cfg_len = 8'd3;
    rst = 1'b0;
    step();
    bus.gpio_i[7] = 1'b1;
    repeat (8) step();
    check("b7_high", bus.gpio_o[7], 1);
    check("b7_no_rise_evt", bus.evt_o, 0);
    bus.cfg_fall[7] = 1'b1;
    bus.gpio_i[7]   = 1'b0;
    n = 0;
    while (n < 20 && bus.gpio_o[7]) begin
      step();
      n++;
    end
    check("b7_fall_latency", n, 6);
    check("b7_fall_evt", bus.evt_o[7], 1);
    check("b7_irq_masked", bus.irq, 0);
    bus.cfg_ien[7] = 1'b1;
    #1;
    check("b7_irq_unmasked", bus.irq, 1);

    // Clear coincident with a new fall commit: set wins
    bus.gpio_i[7] = 1'b1;
    repeat (8) step();
    check("b7_high_again", bus.gpio_o[7], 1);
    bus.gpio_i[7] = 1'b0;
    repeat (5) step();
    check("b7_not_yet", bus.gpio_o[7], 1);
    bus.evt_clr[7] = 1'b1;
    step();
    bus.evt_clr[7] = 1'b0;
    check("b7_committed", bus.gpio_o[7], 0);
    check("b7_set_wins", bus.evt_o[7], 1);
    bus.evt_clr[7] = 1'b1;
    step();
    bus.evt_clr[7] = 1'b0;
    check("b7_cleared", bus.evt_o[7], 0);
    check("b7_irq_cleared", bus.irq, 0);

    // Asynchronous reset mid-count, then full requalification
    do_reset();
    bus.cfg_len  = 8'd3;
    bus.cfg_rise = '1;
    bus.cfg_ien  = '1;
    rst = 1'b0;
    step();
    bus.gpio_i[0] = 1'b1;
    repeat (8) step();
    check("pre_rst_irq", bus.irq, 1);
    bus.gpio_i[3] = 1'b1;
    repeat (4) step();
    check("pre_rst_b3_pending", bus.gpio_o[3], 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_gpio", bus.gpio_o, 0);
    check("async_rst_evt", bus.evt_o, 0);
    check("async_rst_irq", bus.irq, 0);
    step();
    rst = 1'b0;
    n = 0;
    while (n < 20 && !bus.gpio_o[3]) begin
      step();
      n++;
    end
    check("requal_latency", n, 6);
    check("requal_evt", bus.evt_o[3], 1);

`ifdef GPIO_DEBOUNCE_PRESCALER_EN
    do_reset();
    bus.cfg_len = 8'd1;
    bus.cfg_div = 16'd9;
    rst = 1'b0;
    repeat (3) step();
    bus.gpio_i[2] = 1'b1;
    n = 0;
    while (n < 40 && !bus.gpio_o[2]) begin
      step();
      n++;
    end
    check("presc_latency_in_window", (n >= 13 && n <= 22), 1);
`endif

    // Randomized run against the reference model
`ifdef GPIO_DEBOUNCE_PRESCALER_EN
    d = 2;
`else
    d = 0;
`endif
    do_reset();
    bus.cfg_len  = CW'($urandom_range(0, 3));
    bus.cfg_div  = PW'(d);
    bus.cfg_rise = $urandom;
    bus.cfg_fall = $urandom;
    bus.cfg_ien  = $urandom;
    m_s1 = '0; m_s2 = '0; m_out = '0; m_evt = '0; ht = '0;
    for (int i = 0; i < GW; i++) hd[i] = '0;
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bus.gpio_i  = bus.gpio_i ^ ($urandom & $urandom & $urandom);
      bus.evt_clr = $urandom & $urandom & $urandom;
      if (c % 250 == 249) begin
        bus.cfg_len  = CW'($urandom_range(0, 3));
        bus.cfg_rise = $urandom;
        bus.cfg_fall = $urandom;
        bus.cfg_ien  = $urandom;
`ifndef GPIO_DEBOUNCE_PRESCALER_EN
        bus.cfg_div  = PW'($urandom);
`endif
      end
      @(posedge clk);
      model_edge(c, d);
      #1;
      check($sformatf("rnd_gpio_c%0d", c), bus.gpio_o, m_out);
      check($sformatf("rnd_evt_c%0d", c), bus.evt_o, m_evt);
      check($sformatf("rnd_irq_c%0d", c), bus.irq, |(m_evt & bus.cfg_ien));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
